// File: rtl/hazard_controller.sv
// hazard_controller: load-use / branch-dependency stall sequencer with IF/ID flush
// and a saturating stall-cycle counter for the 5-stage MIPS pipeline.
module hazard_controller #(
  parameter int CNT_W    = 16,
  parameter int LB_STALL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             ID_BranchTaken,
  input  logic             ID_Jump,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_Reg_Write,
  input  logic             MEM_MemRead,
  input  logic [4:0]       MEM_Reg_Write,
  input  logic             mem_busy,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cycles
);
  typedef enum logic {RUN, STALL} state_t;
  state_t           r_state, w_state_next;
  logic [1:0]       r_rem, w_rem_next;
  logic [CNT_W-1:0] r_cnt;
  logic w_dep_ex, w_dep_mem, w_lb, w_lu, w_ba, w_bm, w_stall, w_redirect;
  assign w_dep_ex  = (EX_Reg_Write != 5'd0) &&
                     ((EX_Reg_Write == ID_rs) || (ID_UsesRt && (EX_Reg_Write == ID_rt)));
  assign w_dep_mem = (MEM_Reg_Write != 5'd0) &&
                     ((MEM_Reg_Write == ID_rs) || (ID_UsesRt && (MEM_Reg_Write == ID_rt)));
  assign w_lb = EX_MemRead && ID_Branch && w_dep_ex;
  assign w_lu = EX_MemRead && !ID_Branch && w_dep_ex;
  assign w_ba = ID_Branch && EX_RegWrite && !EX_MemRead && w_dep_ex;
  assign w_bm = ID_Branch && MEM_MemRead && w_dep_mem;
  // Only LB can need more than one cycle, so priority only matters for its length.
  assign w_stall    = (r_state == STALL) || w_lb || w_lu || w_ba || w_bm;
  assign w_redirect = ID_Jump || (ID_Branch && ID_BranchTaken);
  always_comb begin
    w_state_next = r_state;
    w_rem_next   = r_rem;
    if (r_state == STALL) begin
      w_state_next = (r_rem <= 2'd1) ? RUN : STALL;
      w_rem_next   = (r_rem == 2'd0) ? 2'd0 : r_rem - 2'd1;
    end else if (w_lb && (LB_STALL > 1)) begin
      w_state_next = STALL;
      w_rem_next   = 2'(LB_STALL - 1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= RUN;
      r_rem   <= 2'd0;
      r_cnt   <= '0;
    end else if (!mem_busy) begin
      r_state <= w_state_next;
      r_rem   <= w_rem_next;
      if (w_stall && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
  assign pipe_freeze  = rst && mem_busy;
  assign PC_Write     = rst && !mem_busy && !w_stall;
  assign IF_ID_Write  = rst && !mem_busy && !w_stall;
  assign ID_EX_Flush  = !rst || (!mem_busy && w_stall);
  assign IF_ID_Flush  = !rst || (!mem_busy && !w_stall && w_redirect);
  assign stall_cycles = r_cnt;
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed and random checks of hazard_controller against
// a pending-stall-count reference model.
module tb_hazard_controller;
  localparam int LBS = 2;
  localparam int CMAX = 65535;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] ID_rs, ID_rt, EX_Reg_Write, MEM_Reg_Write;
  logic ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump;
  logic EX_MemRead, EX_RegWrite, MEM_MemRead, mem_busy;
  logic PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, pipe_freeze;
  logic [15:0] stall_cycles;
  int errs = 0;
  int checks = 0;
  int m_pend = 0;
  int m_cnt = 0;

  hazard_controller #(.CNT_W(16), .LB_STALL(LBS)) dut (
    .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_Reg_Write(EX_Reg_Write),
    .MEM_MemRead(MEM_MemRead), .MEM_Reg_Write(MEM_Reg_Write), .mem_busy(mem_busy),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Flush(ID_EX_Flush), .pipe_freeze(pipe_freeze), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic bit dep(input int x);
    return (x != 0) && (x == int'(ID_rs) || (ID_UsesRt && x == int'(ID_rt)));
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ID_rs = 0; ID_rt = 0; ID_UsesRt = 0; ID_Branch = 0; ID_BranchTaken = 0; ID_Jump = 0;
    EX_MemRead = 0; EX_RegWrite = 0; EX_Reg_Write = 0; MEM_MemRead = 0; MEM_Reg_Write = 0;
    mem_busy = 0; rst = 1;
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
  task automatic tick(input string tag);
    int len;
    bit stall;
    logic [4:0] e;
    @(negedge clk);
    len = 0;
    if (EX_MemRead && dep(int'(EX_Reg_Write))) len = ID_Branch ? LBS : 1;
    else if (ID_Branch && EX_RegWrite && dep(int'(EX_Reg_Write))) len = 1;
    else if (ID_Branch && MEM_MemRead && dep(int'(MEM_Reg_Write))) len = 1;
    stall = (m_pend > 0) || (len > 0);
    if (!rst) e = 5'b00110;
    else if (mem_busy) e = 5'b00001;
    else if (stall) e = 5'b00010;
    else e = {2'b11, ID_Jump || (ID_Branch && ID_BranchTaken), 2'b00};
    chk({tag, ".PC_Write"}, 16'(PC_Write), 16'(e[4]));
    chk({tag, ".IF_ID_Write"}, 16'(IF_ID_Write), 16'(e[3]));
    chk({tag, ".IF_ID_Flush"}, 16'(IF_ID_Flush), 16'(e[2]));
    chk({tag, ".ID_EX_Flush"}, 16'(ID_EX_Flush), 16'(e[1]));
    chk({tag, ".pipe_freeze"}, 16'(pipe_freeze), 16'(e[0]));
    chk({tag, ".stall_cycles"}, stall_cycles, 16'(m_cnt));
    @(posedge clk);
    if (!rst) begin
      m_pend = 0;
      m_cnt = 0;
    end else if (!mem_busy && stall) begin
      m_pend = (m_pend > 0) ? m_pend - 1 : len - 1;
      if (m_cnt < CMAX) m_cnt++;
    end
    #1;
  endtask

  initial begin
    idle();
    rst = 0;
    @(posedge clk);
    #1;
    tick("reset0");
    tick("reset1");
    rst = 1;
    tick("idle");
    EX_MemRead = 1; EX_Reg_Write = 8; ID_rs = 8;
    tick("lu_stall");
    idle();
    tick("lu_after");
    chk("lu_count", stall_cycles, 16'd1);
    EX_MemRead = 1; EX_Reg_Write = 9; ID_Branch = 1; ID_rt = 9; ID_UsesRt = 1; ID_BranchTaken = 1;
    tick("lb_stall1");
    tick("lb_stall2");
    EX_MemRead = 0; EX_Reg_Write = 0;
    tick("lb_proceed");
    idle();
    chk("lb_count", stall_cycles, 16'd3);
    EX_RegWrite = 1; EX_Reg_Write = 5; ID_rs = 5; ID_Branch = 1;
    tick("ba_stall");
    EX_RegWrite = 0; ID_BranchTaken = 1;
    tick("ba_taken");
    idle();
    MEM_MemRead = 1; MEM_Reg_Write = 7; ID_rt = 7; ID_UsesRt = 1; ID_Branch = 1;
    tick("bm_stall");
    idle();
    EX_MemRead = 1; EX_RegWrite = 1; EX_Reg_Write = 0; ID_rs = 0; ID_Branch = 1;
    tick("zero_reg");
    idle();
    EX_RegWrite = 1; EX_Reg_Write = 3; ID_rt = 3; ID_UsesRt = 0; ID_Branch = 1;
    tick("rt_unused");
    idle();
    ID_Jump = 1;
    tick("jump");
    idle();
    EX_MemRead = 1; EX_Reg_Write = 4; ID_rs = 4; ID_Branch = 1;
    tick("mb_lb1");
    mem_busy = 1;
    repeat (3) tick("mb_freeze");
    mem_busy = 0;
    tick("mb_resume");
    idle();
    tick("mb_done");
    EX_MemRead = 1; EX_Reg_Write = 6; ID_rs = 6; ID_Branch = 1;
    tick("rst_lb1");
    rst = 0;
    tick("rst_mid");
    idle();
    tick("rst_after");
    chk("rst_count", stall_cycles, 16'd0);
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 49) != 0);
      mem_busy = ($urandom_range(0, 5) == 0);
      ID_rs = 5'($urandom_range(0, 3));
      ID_rt = 5'($urandom_range(0, 3));
      EX_Reg_Write = 5'($urandom_range(0, 3));
      MEM_Reg_Write = 5'($urandom_range(0, 3));
      {ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump} = 4'($urandom);
      {EX_MemRead, EX_RegWrite, MEM_MemRead} = 3'($urandom);
      tick("rand");
    end
    idle();
    tick("pre_sat");
    EX_MemRead = 1; EX_Reg_Write = 2; ID_rs = 2;
    repeat (CMAX) @(posedge clk);
    #1;
    m_cnt = (m_cnt + CMAX > CMAX) ? CMAX : m_cnt + CMAX;
    tick("sat1");
    tick("sat2");
    chk("sat_hold", stall_cycles, 16'hFFFF);
    idle();
    tick("sat_end");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Pipeline hazard sequencer for the 5-stage MIPS datapath. It sits beside the two forwarding units. It detects hazards that forwarding cannot cover: load-use, and a branch that depends on an in-flight result. For each one it stalls PC and IF/ID for the required number of cycles and injects bubbles into ID/EX. It also flushes IF/ID on a taken branch or a jump, and keeps a saturating stall-cycle counter for performance checks.

Parameters:
CNT_W, 16, width of the stall-cycle counter.
LB_STALL, 2, stall cycles for a branch in ID that depends on a load in EX (legal range 1..3).

Ports:
clk  input  1  clock; all state updates on the posedge.
rst  input  1  synchronous reset, active-low.
ID_rs  input  5  rs field of the instruction in ID.
ID_rt  input  5  rt field of the instruction in ID.
ID_UsesRt  input  1  the ID instruction reads rt as a source.
ID_Branch  input  1  the ID instruction is a conditional branch (compared in ID).
ID_BranchTaken  input  1  branch compare result in ID; valid only when ID_Branch=1.
ID_Jump  input  1  the ID instruction is j, jal or jr.
EX_MemRead  input  1  the EX instruction is a load.
EX_RegWrite  input  1  the EX instruction writes a register.
EX_Reg_Write  input  5  EX destination register.
MEM_MemRead  input  1  the MEM instruction is a load.
MEM_Reg_Write  input  5  MEM destination register.
mem_busy  input  1  external memory stall; freezes the whole pipeline.
PC_Write  output  1  PC enable.
IF_ID_Write  output  1  IF/ID enable.
IF_ID_Flush  output  1  zero the IF/ID register.
ID_EX_Flush  output  1  load a bubble (all control fields 0) into ID/EX.
pipe_freeze  output  1  hold every pipeline register (mem_busy path).
stall_cycles  output  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Match terms. Define rsm(X) = (X != 0) && (X == ID_rs). Define rtm(X) = (X != 0) && ID_UsesRt && (X == ID_rt). Define dep(X) = rsm(X) || rtm(X).
- Hazard terms, evaluated only in state RUN:
  - LU: EX_MemRead && dep(EX_Reg_Write) && !ID_Branch. Stall length 1.
  - LB: EX_MemRead && ID_Branch && dep(EX_Reg_Write). Stall length LB_STALL.
  - BA: ID_Branch && EX_RegWrite && !EX_MemRead && dep(EX_Reg_Write). Stall length 1.
  - BM: ID_Branch && MEM_MemRead && dep(MEM_Reg_Write). Stall length 1.
  - Priority: LB > LU > BA > BM. Only one hazard is taken per cycle.
- State machine. States: RUN, STALL. There is also a remaining-cycle register rem, 2 bits wide.
  - RUN, hazard detected, length L: assert stall outputs this cycle. If L > 1, go to STALL with rem = L-1. Otherwise stay in RUN.
  - STALL: assert stall outputs, decrement rem, return to RUN when rem reaches 1 this cycle. Hazard inputs are ignored in STALL.
- Stall outputs, combinational (Mealy, same cycle): PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0.
- RUN with no hazard:
  - PC_Write=1, IF_ID_Write=1, ID_EX_Flush=0.
  - IF_ID_Flush = ID_Jump || (ID_Branch && ID_BranchTaken).
  - A branch under stall never flushes. The flush fires only in the cycle the branch finally proceeds.
- mem_busy=1 has the highest priority over everything:
  - pipe_freeze=1, PC_Write=0, IF_ID_Write=0, ID_EX_Flush=0, IF_ID_Flush=0.
  - State, rem and stall_cycles hold their values.
  - A stall interrupted by mem_busy resumes with the same rem once mem_busy drops.
- Otherwise pipe_freeze=0.
- stall_cycles increments by 1 on every clock edge where the stall outputs are asserted and mem_busy=0. It saturates at all-ones.
- Reset (rst=0 at posedge): state=RUN, rem=0, stall_cycles=0. While rst=0 the outputs are forced to PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, pipe_freeze=0. Reset mid-stall aborts the stall.
- Register $0 never causes a hazard.

Test Plan:
- Load-use on rs: EX_MemRead=1, EX_Reg_Write=8, ID_rs=8, ID_Branch=0 -> exactly 1 cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; stall_cycles=1; next cycle RUN.
- Load followed by branch: EX_MemRead=1, EX_Reg_Write=9, ID_Branch=1, ID_rt=9, ID_UsesRt=1 -> 2 consecutive stall cycles; IF_ID_Flush=0 during both; stall_cycles=2.
- Branch in ID depending on an ALU op in EX: EX_RegWrite=1, EX_MemRead=0, EX_Reg_Write=5, ID_rs=5, ID_Branch=1 -> 1 stall. The next cycle, with ID_BranchTaken=1 and no hazard remaining, gives IF_ID_Flush=1 for 1 cycle.
- Register $0 and jumps: EX_MemRead=1, EX_Reg_Write=0, ID_rs=0 -> no stall. ID_Jump=1 -> IF_ID_Flush=1 with PC_Write=1.
- mem_busy mid-stall: assert mem_busy in the 1st LB stall cycle for 3 cycles -> pipe_freeze=1 and counter held. After release, 1 remaining stall cycle follows; total stall_cycles=2.
- Reset and saturation: rst=0 during STALL -> RUN and counter=0 next edge. Preload the counter to 16'hFFFF via repeated stalls (or force), trigger another stall -> value stays 16'hFFFF.
